pio_debounce_irq: RTL and testbench

Parametrised Avalon-MM parallel I/O peripheral for the Nios system, replacing the fixed-width button/switch/LED PIOs. It synchronises and debounces every input bit and captures a selectable edge per bit. A masked interrupt is raised on any captured edge. It also drives a writable output port (LEDs or a HEX digit).

---
 rtl/pio_pkg.sv | 27 ++
 rtl/pio_debounce_bit.sv | 64 ++++++
 rtl/pio_debounce_irq.sv | 109 ++++++++++
 tb/tb_pio_debounce_irq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared constants and helpers for the debounced PIO peripheral
//
// Purpose: register word addresses and the counter-width helper used by
//          pio_debounce_irq and pio_debounce_bit.
// Ports:   none (package).

package pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_EDGESEL = 2'd3;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(50000) = 16.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// rtl/pio_debounce_bit.sv - one-bit synchroniser and debouncer
//
// Purpose: brings one asynchronous pin into the clock domain through two
//          flops, then accepts a new level only after it has disagreed with
//          the accepted level for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   i_clk     in   system clock
//   i_rst     in   asynchronous active-high reset
//   i_din     in   raw asynchronous pin
//   o_stable  out  debounced level
//   o_chg     out  high for the cycle whose rising edge toggles o_stable

module pio_debounce_bit
    import pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VAL       = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    output logic o_stable,
    output logic o_chg
);

    localparam int            CW       = clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;

    logic          w_differ;
    logic          w_accept;

    assign w_differ = (r_sync2 != r_stable);
    // Combinational so the caller sees the change on the same edge stable flips.
    assign w_accept = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1  <= RESET_VAL;
            r_sync2  <= RESET_VAL;
            r_stable <= RESET_VAL;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_din;
            r_sync2 <= r_sync1;
            if (w_accept) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_chg    = w_accept;

endmodule

// File: rtl/pio_debounce_irq.sv
// rtl/pio_debounce_irq.sv - Avalon-MM PIO with debounced inputs, edge capture and irq
//
// Purpose: debounces IN_WIDTH input pins, captures a selectable edge per bit,
//          raises a masked level interrupt and drives an OUT_WIDTH output port.
// Ports:
//   clk_clk      in   system clock
//   reset_reset  in   asynchronous active-high reset
//   address      in   register word address (DATA, IRQMASK, EDGECAP, EDGESEL)
//   read/write   in   bus strobes, no waitrequest
//   writedata    in   write data
//   readdata     out  registered read data, latency 1
//   irq          out  |(EDGECAP & IRQMASK)
//   in_port      in   asynchronous input pins
//   out_port     out  output register

module pio_debounce_irq
    import pio_pkg::*;
#(
    parameter int                  IN_WIDTH        = 10,
    parameter int                  OUT_WIDTH       = 9,
    parameter int                  DEBOUNCE_CYCLES = 50000,
    parameter logic [IN_WIDTH-1:0] IN_RESET_VALUE  = {IN_WIDTH{1'b1}}
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [1:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic                 irq,
    input  logic [IN_WIDTH-1:0]  in_port,
    output logic [OUT_WIDTH-1:0] out_port
);

    logic [IN_WIDTH-1:0]  w_stable;
    logic [IN_WIDTH-1:0]  w_chg;
    logic [IN_WIDTH-1:0]  w_capture;
    logic [IN_WIDTH-1:0]  w_cap_clr;
    logic [31:0]          w_rd_mux;
    logic                 w_unused;

    logic [IN_WIDTH-1:0]  r_irqmask;
    logic [IN_WIDTH-1:0]  r_edgecap;
    logic [IN_WIDTH-1:0]  r_edgesel;
    logic [OUT_WIDTH-1:0] r_out;
    logic [31:0]          r_readdata;

    for (genvar g = 0; g < IN_WIDTH; g++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (IN_RESET_VALUE[g])
        ) u_bit (
            .i_clk    (clk_clk),
            .i_rst    (reset_reset),
            .i_din    (in_port[g]),
            .o_stable (w_stable[g]),
            .o_chg    (w_chg[g])
        );
    end

    // w_stable is still the old level while chg is high, so the new level is
    // its complement: rising (sel 0) needs old 0, falling (sel 1) needs old 1.
    assign w_capture = w_chg & ~(w_stable ^ r_edgesel);
    assign w_cap_clr = (write && address == ADDR_EDGECAP) ? writedata[IN_WIDTH-1:0] : '0;

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:    w_rd_mux = 32'(w_stable);
            ADDR_IRQMASK: w_rd_mux = 32'(r_irqmask);
            ADDR_EDGECAP: w_rd_mux = 32'(r_edgecap);
            ADDR_EDGESEL: w_rd_mux = 32'(r_edgesel);
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_edgesel  <= '0;
            r_out      <= '0;
            r_readdata <= '0;
        end else begin
            if (read) begin
                r_readdata <= w_rd_mux;
            end
            if (write && address == ADDR_DATA) begin
                r_out <= writedata[OUT_WIDTH-1:0];
            end
            if (write && address == ADDR_IRQMASK) begin
                r_irqmask <= writedata[IN_WIDTH-1:0];
            end
            if (write && address == ADDR_EDGESEL) begin
                r_edgesel <= writedata[IN_WIDTH-1:0];
            end
            // Capture is OR'd in after the clear so a coincident edge survives.
            r_edgecap <= (r_edgecap & ~w_cap_clr) | w_capture;
        end
    end

    assign w_unused = ^writedata;

    assign readdata = r_readdata;
    assign out_port = r_out;
    assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_pio_debounce_irq.sv
// tb/tb_pio_debounce_irq.sv - self-checking bench for pio_debounce_irq

module tb_pio_debounce_irq;

    localparam int IW = 10;
    localparam int OW = 9;
    localparam int DB = 4;

    logic          clk_clk     = 1'b0;
    logic          reset_reset = 1'b0;
    logic [1:0]    address     = '0;
    logic          read        = 1'b0;
    logic          write       = 1'b0;
    logic [31:0]   writedata   = '0;
    logic [31:0]   readdata;
    logic          irq;
    logic [IW-1:0] in_port     = '1;
    logic [OW-1:0] out_port;

    always #5 clk_clk = ~clk_clk;

    pio_debounce_irq #(
        .IN_WIDTH        (IW),
        .OUT_WIDTH       (OW),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .irq         (irq),
        .in_port     (in_port),
        .out_port    (out_port)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pins seen two samples late, a new level is accepted
    // after DB consecutive disagreeing samples.
    logic [IW-1:0] pin_hist[$];
    logic [IW-1:0] m_stable, m_mask, m_cap, m_sel;
    logic [OW-1:0] m_out;
    int            m_run[IW];
    logic [31:0]   m_rd;
    logic          m_rd_valid;

    task automatic model_reset();
        pin_hist.delete();
        m_stable   = '1;
        m_mask     = '0;
        m_cap      = '0;
        m_sel      = '0;
        m_out      = '0;
        m_rd       = '0;
        m_rd_valid = 1'b0;
        for (int i = 0; i < IW; i++) m_run[i] = 0;
    endtask

    task automatic model_edge();
        logic [IW-1:0] seen;
        logic [IW-1:0] newcap;
        logic [31:0]   rd;
        seen = (pin_hist.size() >= 2) ? pin_hist[pin_hist.size()-2] : '1;
        case (address)
            2'd0:    rd = 32'(m_stable);
            2'd1:    rd = 32'(m_mask);
            2'd2:    rd = 32'(m_cap);
            default: rd = 32'(m_sel);
        endcase
        newcap = '0;
        for (int i = 0; i < IW; i++) begin
            if (seen[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_stable[i] = ~m_stable[i];
                    m_run[i]    = 0;
                    if (m_stable[i] != m_sel[i]) newcap[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (write) begin
            case (address)
                2'd0:    m_out  = writedata[OW-1:0];
                2'd1:    m_mask = writedata[IW-1:0];
                2'd2:    m_cap  = m_cap & ~writedata[IW-1:0];
                default: m_sel  = writedata[IW-1:0];
            endcase
        end
        m_cap = m_cap | newcap;
        m_rd_valid = read && !write;
        if (m_rd_valid) m_rd = rd;
        pin_hist.push_back(in_port);
        if (pin_hist.size() > 2) void'(pin_hist.pop_front());
    endtask

    task automatic step();
        @(posedge clk_clk);
        if (!reset_reset) model_edge();
        #1;
        check_eq("irq", 32'(irq), 32'(|(m_cap & m_mask)));
        check_eq("out_port", 32'(out_port), 32'(m_out));
        if (m_rd_valid) check_eq("readdata", readdata, m_rd);
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        step();
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a; read = 1'b1;
        step();
    endtask

    task automatic do_reset(input int cycles);
        reset_reset = 1'b1;
        read = 1'b0;
        write = 1'b0;
        model_reset();
        #1;
        check_eq("rst_readdata", readdata, 32'h0);
        check_eq("rst_out_port", 32'(out_port), 32'h0);
        check_eq("rst_irq", 32'(irq), 32'h0);
        steps(cycles);
        reset_reset = 1'b0;
    endtask

    initial begin
        #2;
        do_reset(3);

        // Reset values through the bus
        bus_read(2'd0); check_eq("t1_data", readdata, 32'h3FF);
        bus_read(2'd1); check_eq("t1_mask", readdata, 32'h0);
        bus_read(2'd2); check_eq("t1_cap", readdata, 32'h0);
        bus_read(2'd3); check_eq("t1_sel", readdata, 32'h0);

        // Output port
        bus_write(2'd0, 32'h1A5);      check_eq("t2_out_a", 32'(out_port), 32'h1A5);
        bus_write(2'd0, 32'hFFFF_FFFF); check_eq("t2_out_b", 32'(out_port), 32'h1FF);

        // Glitch rejection then a held falling edge on bit 0
        bus_write(2'd1, 32'h001);
        bus_write(2'd3, 32'h001);
        in_port[0] = 1'b0; steps(3);
        in_port[0] = 1'b1; steps(8);
        bus_read(2'd0); check_eq("t3_glitch_data", readdata, 32'h3FF);
        bus_read(2'd2); check_eq("t3_glitch_cap", readdata, 32'h0);
        in_port[0] = 1'b0;
        steps(5); check_eq("t3_irq_before", 32'(irq), 32'h0);
        steps(1); check_eq("t3_irq_at6", 32'(irq), 32'h1);
        bus_read(2'd0); check_eq("t3_data", readdata, 32'h3FE);
        bus_read(2'd2); check_eq("t3_cap", readdata, 32'h001);

        // Clear, then an unselected rising edge
        bus_write(2'd2, 32'h001); check_eq("t4_irq_clr", 32'(irq), 32'h0);
        in_port[0] = 1'b1; steps(8);
        bus_read(2'd2); check_eq("t4_cap", readdata, 32'h0);

        // Capture and clear of bit 3 on the same edge
        bus_write(2'd1, 32'h009);
        in_port[3] = 1'b0; steps(8);
        bus_read(2'd2); check_eq("t5_fall_nocap", readdata, 32'h0);
        in_port[3] = 1'b1; steps(5);
        bus_write(2'd2, 32'h008); check_eq("t5_irq", 32'(irq), 32'h1);
        bus_read(2'd2); check_eq("t5_cap", readdata, 32'h008);

        // Reset two cycles into a debounce
        in_port[5] = 1'b0; steps(2);
        do_reset(2);
        steps(5);
        bus_read(2'd0); check_eq("t6_data_early", readdata, 32'h3FF);
        bus_read(2'd0); check_eq("t6_data", readdata, 32'h3DF);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < IW; b++)
                if ($urandom_range(15) == 0) in_port[b] = ~in_port[b];
            case ($urandom_range(5))
                0, 1: begin
                    address = 2'($urandom_range(3));
                    read    = 1'b1;
                end
                2: begin
                    address   = 2'($urandom_range(3));
                    writedata = $urandom;
                    write     = 1'b1;
                end
                default: ;
            endcase
            if (c == 1500) do_reset(2);
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
